// File: rtl/mc_alu.sv
// rtl/mc_alu.sv - multi-cycle ALU: single-cycle ops plus iterative MULU/DIVU/REMU
// Valid/ready on both sides; results held in DONE until consumed.
module mc_alu #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             resetn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       aluc,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             z,
  output logic             ge,
  output logic             busy
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_SUB  = 4'b0100;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0010;
  localparam logic [3:0] OP_LUI  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0111;
  localparam logic [3:0] OP_SRA  = 4'b1111;
  localparam logic [3:0] OP_SGEU = 4'b1011;
  localparam logic [3:0] OP_HAMD = 4'b1000;
  localparam logic [3:0] OP_MULU = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1001;
  localparam logic [3:0] OP_REMU = 4'b1101;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state;
  logic [3:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;

  function automatic logic [WIDTH-1:0] popcount(input logic [WIDTH-1:0] v);
    logic [WIDTH-1:0] c;
    c = '0;
    for (int i = 0; i < WIDTH; i++) begin
      c = c + {{(WIDTH-1){1'b0}}, v[i]};
    end
    return c;
  endfunction

  logic             is_iter;
  logic [WIDTH-1:0] sc_result;

  assign is_iter = (aluc == OP_MULU) || (aluc == OP_DIVU) || (aluc == OP_REMU);

  always_comb begin
    sc_result = '0;
    case (aluc)
      OP_ADD:  sc_result = a + b;
      OP_SUB:  sc_result = a - b;
      OP_AND:  sc_result = a & b;
      OP_OR:   sc_result = a | b;
      OP_XOR:  sc_result = a ^ b;
      OP_LUI:  sc_result = b << (WIDTH / 2);
      OP_SLL:  sc_result = b << a[SHW-1:0];
      OP_SRL:  sc_result = b >> a[SHW-1:0];
      OP_SRA:  sc_result = $signed(b) >>> a[SHW-1:0];
      OP_SGEU: sc_result = {{(WIDTH-1){1'b0}}, (a >= b)};
      OP_HAMD: sc_result = popcount(a ^ b);
      default: sc_result = '0;
    endcase
  end

  // MSB-first iteration: cnt doubles as the bit index of b (multiply) or a (divide).
  logic [WIDTH-1:0] acc_nxt;
  logic [WIDTH-1:0] rem_sh;
  logic             rem_ge;
  logic [WIDTH-1:0] rem_nxt;
  logic [WIDTH-1:0] quo_nxt;
  logic [WIDTH-1:0] iter_result;

  always_comb begin
    acc_nxt = {acc[WIDTH-2:0], 1'b0} + (b_r[cnt] ? a_r : '0);
    rem_sh  = {rem[WIDTH-2:0], a_r[cnt]};
    // The shifted remainder is WIDTH+1 bits wide; its top bit alone means it exceeds b.
    rem_ge  = rem[WIDTH-1] | (rem_sh >= b_r);
    rem_nxt = rem_ge ? (rem_sh - b_r) : rem_sh;
    quo_nxt = {quo[WIDTH-2:0], rem_ge};
    case (op_r)
      OP_MULU: iter_result = acc_nxt;
      OP_DIVU: iter_result = quo_nxt;
      default: iter_result = rem_nxt;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state     <= S_IDLE;
      op_r      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      cnt       <= '0;
      acc       <= '0;
      quo       <= '0;
      rem       <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      s         <= '0;
      z         <= 1'b0;
      ge        <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_r      <= a;
            b_r      <= b;
            op_r     <= aluc;
            in_ready <= 1'b0;
            if (is_iter) begin
              acc   <= '0;
              quo   <= '0;
              rem   <= '0;
              cnt   <= SHW'(WIDTH - 1);
              busy  <= 1'b1;
              state <= S_BUSY;
            end else begin
              s         <= sc_result;
              z         <= (sc_result == '0);
              ge        <= (a >= b);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          acc <= acc_nxt;
          quo <= quo_nxt;
          rem <= rem_nxt;
          if (cnt == '0) begin
            s         <= iter_result;
            z         <= (iter_result == '0);
            ge        <= (a_r >= b_r);
            busy      <= 1'b0;
            out_valid <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/mc_alu.md
# mc_alu

- Parametrised multi-cycle ALU for the next CPU datapath generation.
- Keeps the single-cycle operations of the current ALU and adds:
  - Hamming distance.
  - Unsigned multiply, divide and remainder, computed iteratively.
  - Valid/ready handshakes on both input and output, so the pipeline can stall on long operations.
- Sits between the ID/EX operand registers and the EX/MEM register.
- Results and flags are registered and stay stable until consumed.

## Interface
Parameters:
- WIDTH, 32, operand/result width; power of two, at least 8.
- SHW, log2(WIDTH), shift-amount width; derived, not overridden.

Ports:
- clock  in  1  rising-edge clock.
- resetn  in  1  reset; one clock; asynchronous, active-low.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept a request.
- a  in  WIDTH  operand A; a[SHW-1:0] is the shift amount for shifts.
- b  in  WIDTH  operand B.
- aluc  in  4  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- s  out  WIDTH  result.
- z  out  1  s == 0.
- ge  out  1  a >= b, unsigned, on the accepted operands.
- busy  out  1  iterative operation in progress.

## Operation
- Opcodes; all arithmetic is modulo 2^WIDTH:
  - 0000 ADD a+b; 0100 SUB a-b; 0001 AND; 0101 OR; 0010 XOR.
  - 0110 LUI: b << (WIDTH/2).
  - 0011 SLL: b << a[SHW-1:0]; 0111 SRL: logical right shift; 1111 SRA: arithmetic right shift.
  - 1011 SGEU: s = {0…, a>=b}.
  - 1000 HAMD: popcount(a^b), zero-extended.
  - 1100 MULU: low WIDTH bits of a*b.
  - 1001 DIVU: a/b. 1101 REMU: a%b.
  - 1010 and 1110 are reserved: s = 0, handled as a single-cycle operation.
- Division by zero:
  - DIVU gives all ones; REMU gives a.
  - No exception is raised; latency is unchanged.
- Classes:
  - Iterative: MULU, DIVU, REMU.
  - Single-cycle: everything else.
- Operands and opcode are captured into internal registers at acceptance, so upstream may change them freely afterwards.
- State machine:
  - IDLE, with in_ready = 1.
    - Accept when in_valid & in_ready.
    - Single-cycle op: compute and register s/z/ge, go to DONE.
    - Iterative op: load counter with WIDTH-1, go to BUSY.
  - BUSY, with busy = 1 and in_ready = 0.
    - One shift-add step (MULU) or one restoring-divide step (DIVU/REMU) per cycle.
    - When the counter is 0, register the result and go to DONE.
  - DONE, with out_valid = 1 and in_ready = 0.
    - s, z, ge held constant.
    - out_ready = 1 returns the block to IDLE.
    - No new request is accepted in the same cycle as the result is consumed.
- z and ge are computed from the final s and the captured operands.
- in_valid is ignored in BUSY and DONE; no request is queued.
- Asynchronous reset in any state:
  - Forces IDLE immediately.
  - Discards any in-flight operation.
  - out_valid = 0, busy = 0, s = 0, z = 0, ge = 0, in_ready = 1.
  - Internal accumulator, quotient and counter are cleared.

## Timing
- E0 is the clock edge that samples in_valid & in_ready = 1.
- Single-cycle ops:
  - out_valid rises after E0: 1 cycle latency.
  - Sustained throughput is one result per 2 cycles (DONE→IDLE→accept).
- Iterative ops:
  - busy is high from E0 to E(WIDTH).
  - out_valid rises after E(WIDTH), exactly WIDTH cycles after E0.
- The result is consumed at the edge where out_valid & out_ready = 1.
  - out_valid falls and in_ready rises after that edge.
- Backpressure: out_ready low holds s/z/ge/out_valid bit-stable indefinitely.
- All outputs are registered; no combinational path from inputs to outputs.

## Test plan
WIDTH = 32 throughout.
- ADD: a=0x7FFFFFFF, b=1 → s=0x80000000, z=0, ge=1; out_valid exactly 1 cycle after acceptance. SUB a=b=5 → s=0, z=1.
- SGEU: a=3, b=5 → s=0, z=1, ge=0. SRA: a=4, b=0x80000000 → s=0xF8000000. SLL: a=33, b=1 → s=2, since only the low 5 bits count.
- HAMD: a=0xFFFFFFFF, b=0 → s=32. MULU: a=b=0x10000 → s=0, z=1.
  - busy high and in_ready low for exactly 32 cycles; out_valid after 32 cycles.
  - in_valid pulses during BUSY are ignored.
- DIVU 100/7 → 14; REMU 100%7 → 2. DIVU a=9, b=0 → 0xFFFFFFFF; REMU a=9, b=0 → 9. Each takes 32 cycles.
- Backpressure: out_ready held low for 10 cycles after an ADD → s/z/ge/out_valid unchanged. On release, in_ready returns 1 the next cycle.
- Reset: resetn pulsed low mid-DIVU, at cycle 15 → immediately out_valid=0, busy=0, s=0, in_ready=1. A subsequent ADD 2+2 → s=4.
